// File: rtl/route_compute_mesh_pkg.sv
// Shared definitions for the mesh route-compute stage: flit type codes,
// one-hot output port constants and the packet-tracking FSM states.
package route_compute_mesh_pkg;

    // Flit type lives in the two most significant flit bits
    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_TAIL   = 2'b01,
        FLIT_HEAD   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    // One-hot output port encoding {L,N,S,E,W} at bits [4:0]
    localparam logic [4:0] PORT_L    = 5'b10000;
    localparam logic [4:0] PORT_N    = 5'b01000;
    localparam logic [4:0] PORT_S    = 5'b00100;
    localparam logic [4:0] PORT_E    = 5'b00010;
    localparam logic [4:0] PORT_W    = 5'b00001;
    localparam logic [4:0] PORT_NONE = 5'b00000;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } rc_state_e;

endpackage

// File: rtl/route_compute_mesh_route_select.sv
// Combinational route selection: maps (cur, dst, neighbour stress) to a
// one-hot output port. Minimal adaptive routing between the two productive
// directions when ROUTE_ADAPTIVE_EN is defined, deterministic XY otherwise.
module route_select
    import route_compute_mesh_pkg::*;
#(
    parameter int X_W      = 2,
    parameter int Y_W      = 1,
    parameter int STRESS_W = 3
) (
    input  logic [X_W-1:0]      cur_x,
    input  logic [Y_W-1:0]      cur_y,
    input  logic [X_W-1:0]      dst_x,
    input  logic [Y_W-1:0]      dst_y,
    input  logic [STRESS_W-1:0] stress_e,
    input  logic [STRESS_W-1:0] stress_w,
    input  logic [STRESS_W-1:0] stress_n,
    input  logic [STRESS_W-1:0] stress_s,
    output logic [4:0]          port
);

    logic             dx_s;
    logic             dy_s;
    logic [4:0]       x_port_s;
    logic [4:0]       y_port_s;
    logic             pick_y_s;

`ifdef ROUTE_ADAPTIVE_EN
    logic [STRESS_W-1:0] x_stress_s;
    logic [STRESS_W-1:0] y_stress_s;

    // Stress of the productive X/Y neighbours; ties go to Y
    always_comb begin
        x_stress_s = (dst_x > cur_x) ? stress_e : stress_w;
        y_stress_s = (dst_y > cur_y) ? stress_s : stress_n;
        pick_y_s   = !(x_stress_s < y_stress_s);
    end
`else
    logic stress_sink_s;

    // XY routing never consults stress; the reduction only keeps the inputs referenced
    always_comb begin
        stress_sink_s = ^{stress_e, stress_w, stress_n, stress_s};
        pick_y_s      = stress_sink_s & 1'b0;
    end
`endif

    // Productive direction per axis, then final one-hot select
    always_comb begin
        dx_s     = (dst_x != cur_x);
        dy_s     = (dst_y != cur_y);
        x_port_s = (dst_x > cur_x) ? PORT_E : PORT_W;
        y_port_s = (dst_y > cur_y) ? PORT_S : PORT_N;
        case ({dx_s, dy_s})
            2'b00:   port = PORT_L;
            2'b10:   port = x_port_s;
            2'b01:   port = y_port_s;
            2'b11:   port = pick_y_s ? y_port_s : x_port_s;
            default: port = PORT_NONE;
        endcase
    end

endmodule

// File: rtl/route_compute_mesh.sv
// Mesh router route-compute stage: one-cycle registered pipeline that tags
// each flit with a one-hot output port. Heads lock a route for their packet;
// bodies/tails reuse it. Framing errors drop the flit and pulse err_o.
// Optional feature macro: ROUTE_ADAPTIVE_EN (minimal adaptive routing).
module route_compute_mesh
    import route_compute_mesh_pkg::*;
#(
    parameter int X_W      = 2,
    parameter int Y_W      = 1,
    parameter int DATA_W   = 32,
    parameter int STRESS_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [X_W-1:0]      cur_x,
    input  logic [Y_W-1:0]      cur_y,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [STRESS_W-1:0] stress_e,
    input  logic [STRESS_W-1:0] stress_w,
    input  logic [STRESS_W-1:0] stress_n,
    input  logic [STRESS_W-1:0] stress_s,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [4:0]          out_port,
    output logic                err_o
);

    rc_state_e         state_r;
    rc_state_e         next_state_s;
    logic [4:0]        route_q_r;
    logic [4:0]        next_route_s;
    logic [4:0]        route_s;
    logic [4:0]        sel_port_s;
    logic              legal_s;
    logic              accept_s;
    flit_type_e        ftype_s;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic [4:0]        out_port_r;
    logic              err_r;

    route_select #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .STRESS_W (STRESS_W)
    ) u_route_select (
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .dst_x    (in_data[X_W-1:0]),
        .dst_y    (in_data[X_W+Y_W-1:X_W]),
        .stress_e (stress_e),
        .stress_w (stress_w),
        .stress_n (stress_n),
        .stress_s (stress_s),
        .port     (route_s)
    );

    assign in_ready  = !out_valid_r || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_port  = out_port_r;
    assign err_o     = err_r;

    // Framing check and next state/route for the flit currently offered
    always_comb begin
        ftype_s      = flit_type_e'(in_data[DATA_W-1:DATA_W-2]);
        legal_s      = 1'b0;
        next_state_s = state_r;
        next_route_s = route_q_r;
        sel_port_s   = PORT_NONE;
        case (state_r)
            ST_IDLE: begin
                case (ftype_s)
                    FLIT_HEAD: begin
                        legal_s      = 1'b1;
                        sel_port_s   = route_s;
                        next_route_s = route_s;
                        next_state_s = ST_LOCKED;
                    end
                    FLIT_SINGLE: begin
                        legal_s    = 1'b1;
                        sel_port_s = route_s;
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            ST_LOCKED: begin
                case (ftype_s)
                    FLIT_BODY: begin
                        legal_s    = 1'b1;
                        sel_port_s = route_q_r;
                    end
                    FLIT_TAIL: begin
                        legal_s      = 1'b1;
                        sel_port_s   = route_q_r;
                        next_state_s = ST_IDLE;
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Pipeline register, FSM and error pulse; all frozen under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            route_q_r   <= PORT_NONE;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_port_r  <= PORT_NONE;
            err_r       <= 1'b0;
        end else if (accept_s) begin
            state_r   <= next_state_s;
            route_q_r <= next_route_s;
            err_r     <= !legal_s;
            if (legal_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= in_data;
                out_port_r  <= sel_port_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else begin
            err_r <= 1'b0;
            if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

endmodule

// File: tb/tb_route_compute_mesh.sv
// Directed self-checking bench for route_compute_mesh (default parameters).
// Expected ports are hand-derived; adaptive expectations follow ROUTE_ADAPTIVE_EN.
module tb_route_compute_mesh;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_TAIL   = 2'b01;
    localparam logic [1:0] T_HEAD   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    localparam logic [4:0] P_L = 5'b10000;
    localparam logic [4:0] P_N = 5'b01000;
    localparam logic [4:0] P_S = 5'b00100;
    localparam logic [4:0] P_E = 5'b00010;
    localparam logic [4:0] P_W = 5'b00001;

    logic        clk;
    logic        rst_n;
    logic [1:0]  cur_x;
    logic [0:0]  cur_y;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [2:0]  stress_e, stress_w, stress_n, stress_s;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_port;
    logic        err_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] fa, fb, fc, fd;
    logic [4:0]  exp_port;

    route_compute_mesh dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .stress_e  (stress_e),
        .stress_w  (stress_w),
        .stress_n  (stress_n),
        .stress_s  (stress_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_port  (out_port),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [26:0] pay,
                                       input logic [1:0] dx, input logic dy);
        return {t, pay, dy, dx};
    endfunction

    // Present one flit for one clock edge; outputs are checked #1 after the edge
    task automatic send(input logic [31:0] f);
        in_valid = 1'b1;
        in_data  = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Single flit dst=(2,1) from (0,0) under given E/S stress
    task automatic adapt_case(input string tag, input logic [2:0] se, input logic [2:0] ss,
                              input logic [4:0] exp_adapt);
        stress_e = se;
        stress_s = ss;
        send(mk(T_SINGLE, 27'h0000AA, 2'd2, 1'b1));
`ifdef ROUTE_ADAPTIVE_EN
        check(tag, {27'd0, out_port}, {27'd0, exp_adapt});
`else
        check(tag, {27'd0, out_port}, {27'd0, P_E});
`endif
    endtask

    initial begin
        rst_n = 1'b0; cur_x = 2'd1; cur_y = 1'b0;
        in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1;
        stress_e = 3'd0; stress_w = 3'd0; stress_n = 3'd0; stress_s = 3'd0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_port",  {27'd0, out_port}, 32'd0);
        check("rst_out_data",  out_data, 32'd0);
        check("rst_err",       {31'd0, err_o}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        idle_cycle();

        // Single to self -> L
        fa = mk(T_SINGLE, 27'h1234567, 2'd1, 1'b0);
        send(fa);
        check("local_valid", {31'd0, out_valid}, 32'd1);
        check("local_port",  {27'd0, out_port}, {27'd0, P_L});
        check("local_data",  out_data, fa);
        idle_cycle();
        check("local_drained", {31'd0, out_valid}, 32'd0);

        // Unidirectional routes from (1,0)
        send(mk(T_SINGLE, 27'h1, 2'd3, 1'b0));
        check("uni_east", {27'd0, out_port}, {27'd0, P_E});
        send(mk(T_SINGLE, 27'h2, 2'd0, 1'b0));
        check("uni_west", {27'd0, out_port}, {27'd0, P_W});
        send(mk(T_SINGLE, 27'h3, 2'd1, 1'b1));
        check("uni_south", {27'd0, out_port}, {27'd0, P_S});
        cur_y = 1'b1;
        send(mk(T_SINGLE, 27'h4, 2'd1, 1'b0));
        check("uni_north", {27'd0, out_port}, {27'd0, P_N});

        // Packet head dst=(3,1) from (0,0); route locks despite stress swings
        cur_x = 2'd0; cur_y = 1'b0;
        stress_e = 3'd0; stress_s = 3'd7;
        fa = mk(T_HEAD, 27'h11, 2'd3, 1'b1);
        send(fa);
        check("pkt_head_port", {27'd0, out_port}, {27'd0, P_E});
        check("pkt_head_data", out_data, fa);
        stress_e = 3'd7; stress_s = 3'd0;
        fb = mk(T_BODY, 27'h22, 2'd0, 1'b0);
        send(fb);
        check("pkt_body1_port", {27'd0, out_port}, {27'd0, P_E});
        check("pkt_body1_data", out_data, fb);
        stress_e = 3'd6; stress_s = 3'd1;
        send(mk(T_BODY, 27'h33, 2'd1, 1'b1));
        check("pkt_body2_port", {27'd0, out_port}, {27'd0, P_E});
        fc = mk(T_TAIL, 27'h44, 2'd2, 1'b0);
        send(fc);
        check("pkt_tail_port", {27'd0, out_port}, {27'd0, P_E});
        check("pkt_tail_data", out_data, fc);
        check("pkt_tail_err",  {31'd0, err_o}, 32'd0);
        // Back in IDLE: a single is accepted and routed
        stress_e = 3'd0; stress_s = 3'd0;
        send(mk(T_SINGLE, 27'h55, 2'd0, 1'b1));
        check("pkt_idle_again_port", {27'd0, out_port}, {27'd0, P_S});
        check("pkt_idle_again_err",  {31'd0, err_o}, 32'd0);

        // Adaptive vs XY on diagonal destination
        adapt_case("adapt_e5_s2", 3'd5, 3'd2, P_S);
        adapt_case("adapt_e1_s2", 3'd1, 3'd2, P_E);
        adapt_case("adapt_tie3",  3'd3, 3'd3, P_S);
        stress_e = 3'd0; stress_s = 3'd0;
        idle_cycle();

        // Body while IDLE is dropped with an error pulse
        send(mk(T_BODY, 27'h66, 2'd1, 1'b0));
        check("orphan_valid", {31'd0, out_valid}, 32'd0);
        check("orphan_err",   {31'd0, err_o}, 32'd1);
        idle_cycle();
        check("orphan_err_pulse", {31'd0, err_o}, 32'd0);
        send(mk(T_HEAD, 27'h77, 2'd0, 1'b1));
        check("orphan_next_head_valid", {31'd0, out_valid}, 32'd1);
        check("orphan_next_head_port",  {27'd0, out_port}, {27'd0, P_S});
        // Head while LOCKED is a framing error, lock kept
        send(mk(T_HEAD, 27'h78, 2'd3, 1'b0));
        check("locked_head_err",   {31'd0, err_o}, 32'd1);
        check("locked_head_valid", {31'd0, out_valid}, 32'd0);
        send(mk(T_TAIL, 27'h79, 2'd3, 1'b0));
        check("locked_tail_port", {27'd0, out_port}, {27'd0, P_S});
        check("locked_tail_err",  {31'd0, err_o}, 32'd0);
        idle_cycle();

        // Backpressure: A held for 4 cycles while B waits, then B,C,D back-to-back
        fa = mk(T_SINGLE, 27'hA, 2'd1, 1'b0);
        fb = mk(T_SINGLE, 27'hB, 2'd0, 1'b1);
        fc = mk(T_SINGLE, 27'hC, 2'd2, 1'b0);
        fd = mk(T_SINGLE, 27'hD, 2'd0, 1'b0);
        out_ready = 1'b0;
        send(fa);
        in_valid = 1'b1;
        in_data  = fb;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid",    {31'd0, out_valid}, 32'd1);
            check("stall_data",     out_data, fa);
            check("stall_port",     {27'd0, out_port}, {27'd0, P_E});
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_b_data", out_data, fb);
        check("b2b_b_port", {27'd0, out_port}, {27'd0, P_S});
        in_data = fc;
        @(posedge clk);
        #1;
        check("b2b_c_data", out_data, fc);
        check("b2b_c_port", {27'd0, out_port}, {27'd0, P_E});
        in_data = fd;
        @(posedge clk);
        #1;
        check("b2b_d_data",  out_data, fd);
        check("b2b_d_port",  {27'd0, out_port}, {27'd0, P_L});
        check("b2b_d_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        idle_cycle();
        check("b2b_drained", {31'd0, out_valid}, 32'd0);

        // Reset after a head discards the lock; a following tail is an error
        send(mk(T_HEAD, 27'hE, 2'd3, 1'b0));
        check("rst_mid_head_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #2;
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_port",  {27'd0, out_port}, 32'd0);
        check("rst_mid_data",  out_data, 32'd0);
        rst_n = 1'b1;
        idle_cycle();
        send(mk(T_TAIL, 27'hF, 2'd3, 1'b0));
        check("rst_mid_tail_err",   {31'd0, err_o}, 32'd1);
        check("rst_mid_tail_valid", {31'd0, out_valid}, 32'd0);
        exp_port = P_E;
        send(mk(T_SINGLE, 27'h10, 2'd3, 1'b0));
        check("rst_mid_single_port", {27'd0, out_port}, {27'd0, exp_port});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
